memory_interface_responder: RTL

- Memory-side responder for the core's word-oriented memory interface (enable / state / address / frame_mask). The interface is driven by the fetch unit and by load/store logic.
- Holds a word-addressed RAM and services byte-masked reads and writes.
- Inserts a programmable number of wait states, then acknowledges with a one-cycle ready pulse.
- Used as the instruction/data memory model in simulation and as the on-chip scratchpad.

---
 rtl/memory_interface_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/memory_interface_responder.sv
// Word-addressed RAM responder for the core memory interface: captures a request,
// waits LATENCY cycles, then pulses ready with byte-masked read data or commits a masked write.
module memory_interface_responder #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  input  logic [31:0] memory_interface_data_in,
  output logic [31:0] memory_interface_data_out,
  output logic        memory_interface_ready
);

  localparam logic       STATE_WRITE = 1'b1;
  localparam logic [3:0] LOAD_COUNT  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t                 r_state, w_next_state;
  logic [3:0]             r_count, w_next_count;
  logic                   r_req_write;
  logic [ADDR_BITS-1:0]   r_req_index;
  logic [3:0]             r_req_mask;
  logic [31:0]            r_req_data;
  logic [31:0]            r_mem [DEPTH];
  logic                   r_ready;
  logic [31:0]            r_data_out;

  logic                   w_capture;
  logic                   w_mem_write;
  logic                   w_enter_respond;
  logic                   w_rd_write;
  logic [ADDR_BITS-1:0]   w_rd_index;
  logic [3:0]             w_rd_mask;
  logic [ADDR_BITS-1:0]   w_addr_index;
  logic                   w_unused_addr_bits;

  // Upper address bits alias the array; the low two bits select bytes, which the mask already covers.
  assign w_addr_index       = memory_interface_address[ADDR_BITS+1:2];
  assign w_unused_addr_bits = ^{memory_interface_address[31:ADDR_BITS+2],
                                memory_interface_address[1:0]};

  function automatic logic [31:0] lane_select(input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
    end
    return result;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_next_count = r_count;
    w_capture    = 1'b0;
    w_mem_write  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (memory_interface_enable) begin
          w_capture = 1'b1;
          if (LATENCY == 0) begin
            w_next_state = ST_RESPOND;
          end else begin
            w_next_state = ST_WAIT;
            w_next_count = LOAD_COUNT;
          end
        end
      end
      ST_WAIT: begin
        if (!memory_interface_enable) begin
          w_next_state = ST_IDLE;
        end else if (r_count == 4'd0) begin
          w_next_state = ST_RESPOND;
        end else begin
          w_next_count = r_count - 4'd1;
        end
      end
      ST_RESPOND: begin
        w_next_state = ST_IDLE;
        w_mem_write  = memory_interface_enable && r_req_write;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // With zero latency RESPOND is entered on the capture edge, so the read uses the live request.
  always_comb begin
    w_enter_respond = (w_next_state == ST_RESPOND);
    w_rd_write      = (r_state == ST_IDLE) ? memory_interface_state      : r_req_write;
    w_rd_index      = (r_state == ST_IDLE) ? w_addr_index                : r_req_index;
    w_rd_mask       = (r_state == ST_IDLE) ? memory_interface_frame_mask : r_req_mask;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_ready    <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_count    <= w_next_count;
      r_ready    <= w_enter_respond;
      r_data_out <= (w_enter_respond && (w_rd_write != STATE_WRITE))
                    ? lane_select(r_mem[w_rd_index], w_rd_mask) : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_capture) begin
      r_req_write <= memory_interface_state;
      r_req_index <= w_addr_index;
      r_req_mask  <= memory_interface_frame_mask;
      r_req_data  <= memory_interface_data_in;
    end
  end

  // NOTE: the RAM has no reset; contents survive reset and only the handshake is cleared.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_req_mask[i]) begin
          r_mem[r_req_index][8*i +: 8] <= r_req_data[8*i +: 8];
        end
      end
    end
  end

  assign memory_interface_ready    = r_ready;
  assign memory_interface_data_out = r_data_out;

endmodule
